id_ex_skid_stage: RTL and testbench

//  Parametrised ID->EX pipeline boundary; replaces a hard-wired stall/flush register.

---
 rtl/id_ex_skid_stage.sv | 188 ++++++++++++++++++
 tb/tb_id_ex_skid_stage.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_skid_stage.sv
// id_ex_skid_stage: ID->EX pipeline boundary with a two-entry skid buffer.
// Holds up to two issue groups of LANES instructions. The head group always
// lives in the main entry; the skid entry catches one extra group so that
// in_ready can be registered, which breaks the EX->ID stall path.
// Control fields are killed on flush; payload is never cleared by flush.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   flush                   kill all held and incoming groups
//   in_valid/in_ctrl/in_data  group offered by ID (lane i at [i*W +: W])
//   in_ready                registered; stage accepts a group this cycle
//   out_valid/out_ctrl/out_data  head group presented to EX
//   out_ready               EX consumes the head group this cycle
//   occupancy               groups held: 0, 1 or 2
module id_ex_skid_stage #(
  parameter int unsigned LANES  = 1,
  parameter int unsigned CTRL_W = 24,
  parameter int unsigned DATA_W = 129
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [LANES-1:0]          in_valid,
  input  logic [LANES*CTRL_W-1:0]   in_ctrl,
  input  logic [LANES*DATA_W-1:0]   in_data,
  output logic                      in_ready,
  output logic [LANES-1:0]          out_valid,
  output logic [LANES*CTRL_W-1:0]   out_ctrl,
  output logic [LANES*DATA_W-1:0]   out_data,
  input  logic                      out_ready,
  output logic [1:0]                occupancy
);

  localparam int unsigned CW = LANES * CTRL_W;
  localparam int unsigned DW = LANES * DATA_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HALF  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic          push, pop;
  logic [CW-1:0] in_ctrl_m;

  // Datapath enables decoded from the current state and handshakes
  logic main_load_in, main_load_skid, main_kill;
  logic skid_load_in, skid_kill;
  logic in_ready_d;
  logic [1:0] occupancy_d;

  // Skid entry
  logic [LANES-1:0] skid_valid;
  logic [CW-1:0]    skid_ctrl;
  logic [DW-1:0]    skid_data;

  assign push = (|in_valid) & in_ready;
  assign pop  = (|out_valid) & out_ready;

  // Zero the control bundle of lanes that are not valid
  always_comb begin
    in_ctrl_m = '0;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (in_valid[i]) begin
        in_ctrl_m[i*CTRL_W +: CTRL_W] = in_ctrl[i*CTRL_W +: CTRL_W];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: if (push) state_d = HALF;
        HALF: begin
          if (push && !pop) begin
            state_d = FULL;
          end else if (pop && !push) begin
            state_d = EMPTY;
          end
        end
        FULL:    if (pop) state_d = HALF;
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output / enable decode
  always_comb begin
    main_load_in   = 1'b0;
    main_load_skid = 1'b0;
    main_kill      = 1'b0;
    skid_load_in   = 1'b0;
    skid_kill      = 1'b0;
    in_ready_d     = (state_d != FULL);
    occupancy_d    = 2'd0;

    unique case (state_d)
      HALF:    occupancy_d = 2'd1;
      FULL:    occupancy_d = 2'd2;
      default: occupancy_d = 2'd0;
    endcase

    if (!flush) begin
      unique case (state_q)
        EMPTY: main_load_in = push;
        HALF: begin
          main_load_in = push & pop;
          skid_load_in = push & ~pop;
          main_kill    = pop & ~push;
        end
        FULL: begin
          main_load_skid = pop;
          skid_kill      = pop;
        end
        default: ;
      endcase
    end
  end

  // Registered handshake and occupancy outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      occupancy <= 2'd0;
    end else begin
      in_ready  <= in_ready_d;
      occupancy <= occupancy_d;
    end
  end

  // Main (head) entry; flush kills valid and ctrl but keeps payload
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= '0;
      out_ctrl  <= '0;
      out_data  <= '0;
    end else if (flush) begin
      out_valid <= '0;
      out_ctrl  <= '0;
    end else if (main_load_in) begin
      out_valid <= in_valid;
      out_ctrl  <= in_ctrl_m;
      out_data  <= in_data;
    end else if (main_load_skid) begin
      out_valid <= skid_valid;
      out_ctrl  <= skid_ctrl;
      out_data  <= skid_data;
    end else if (main_kill) begin
      out_valid <= '0;
      out_ctrl  <= '0;
    end
  end

  // Skid entry; only written when the head is stalled
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      skid_valid <= '0;
      skid_ctrl  <= '0;
      skid_data  <= '0;
    end else if (flush) begin
      skid_valid <= '0;
      skid_ctrl  <= '0;
    end else if (skid_load_in) begin
      skid_valid <= in_valid;
      skid_ctrl  <= in_ctrl_m;
      skid_data  <= in_data;
    end else if (skid_kill) begin
      skid_valid <= '0;
      skid_ctrl  <= '0;
    end
  end

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Bench for id_ex_skid_stage: one LANES=1 and one LANES=2 instance, both
// compared every cycle against a queue-based model, plus literal checks.
module tb_id_ex_skid_stage;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // LANES=1 instance
  logic         flush1, out_ready1, in_ready1;
  logic [0:0]   in_valid1, out_valid1;
  logic [23:0]  in_ctrl1, out_ctrl1;
  logic [128:0] in_data1, out_data1;
  logic [1:0]   occ1;

  // LANES=2 instance
  logic         flush2, out_ready2, in_ready2;
  logic [1:0]   in_valid2, out_valid2;
  logic [47:0]  in_ctrl2, out_ctrl2;
  logic [257:0] in_data2, out_data2;
  logic [1:0]   occ2;

  id_ex_skid_stage #(.LANES(1), .CTRL_W(24), .DATA_W(129)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush1),
    .in_valid(in_valid1), .in_ctrl(in_ctrl1), .in_data(in_data1),
    .in_ready(in_ready1),
    .out_valid(out_valid1), .out_ctrl(out_ctrl1), .out_data(out_data1),
    .out_ready(out_ready1), .occupancy(occ1)
  );

  id_ex_skid_stage #(.LANES(2), .CTRL_W(24), .DATA_W(129)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .flush(flush2),
    .in_valid(in_valid2), .in_ctrl(in_ctrl2), .in_data(in_data2),
    .in_ready(in_ready2),
    .out_valid(out_valid2), .out_ctrl(out_ctrl2), .out_data(out_data2),
    .out_ready(out_ready2), .occupancy(occ2)
  );

  typedef struct packed {
    logic [1:0]   v;
    logic [47:0]  c;
    logic [257:0] d;
  } grp_t;

  // Model: FIFO of at most two groups per instance
  grp_t         mq    [2][2];
  int           mcnt  [2];
  logic         mready[2];
  logic [257:0] mhead [2];

  int tests = 0;
  int fails = 0;

  function automatic void chk(string nm, logic [299:0] act, logic [299:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endfunction

  task automatic model_step(int k, logic fl, logic [1:0] v, logic [47:0] c,
                            logic [257:0] d, logic ordy, int lanes);
    logic p_push, p_pop;
    grp_t g;
    p_push = (|v) && mready[k];
    p_pop  = (mcnt[k] > 0) && ordy;
    if (!rst_n) begin
      mcnt[k]   = 0;
      mready[k] = 1'b1;
      mhead[k]  = '0;
    end else if (fl) begin
      mcnt[k]   = 0;
      mready[k] = 1'b1;
    end else begin
      if (p_pop) begin
        mq[k][0] = mq[k][1];
        mcnt[k]--;
      end
      if (p_push) begin
        g.v = v;
        g.c = c;
        g.d = d;
        for (int j = 0; j < 48; j++) begin
          if (j >= lanes * 24 || !v[j/24]) g.c[j] = 1'b0;
        end
        mq[k][mcnt[k]] = g;
        mcnt[k]++;
      end
      mready[k] = (mcnt[k] < 2);
      if (mcnt[k] > 0) mhead[k] = mq[k][0].d;
    end
  endtask

  task automatic check_all();
    logic [1:0]  ev;
    logic [47:0] ec;
    for (int k = 0; k < 2; k++) begin
      ev = (mcnt[k] > 0) ? mq[k][0].v : 2'b00;
      ec = (mcnt[k] > 0) ? mq[k][0].c : 48'd0;
      if (k == 0) begin
        chk("d1_out_valid", 300'(out_valid1), 300'(ev));
        chk("d1_out_ctrl",  300'(out_ctrl1),  300'(ec));
        chk("d1_out_data",  300'(out_data1),  300'(mhead[0]));
        chk("d1_occupancy", 300'(occ1),       300'(mcnt[0]));
        chk("d1_in_ready",  300'(in_ready1),  300'(mready[0]));
      end else begin
        chk("d2_out_valid", 300'(out_valid2), 300'(ev));
        chk("d2_out_ctrl",  300'(out_ctrl2),  300'(ec));
        chk("d2_out_data",  300'(out_data2),  300'(mhead[1]));
        chk("d2_occupancy", 300'(occ2),       300'(mcnt[1]));
        chk("d2_in_ready",  300'(in_ready2),  300'(mready[1]));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step(0, flush1, {1'b0, in_valid1}, 48'(in_ctrl1), 258'(in_data1), out_ready1, 1);
    model_step(1, flush2, in_valid2, in_ctrl2, in_data2, out_ready2, 2);
    @(negedge clk);
    check_all();
  endtask

  task automatic drive1(logic v, logic [23:0] c, logic [128:0] d, logic ordy, logic fl);
    in_valid1 = v; in_ctrl1 = c; in_data1 = d; out_ready1 = ordy; flush1 = fl;
  endtask

  task automatic drive2(logic [1:0] v, logic [47:0] c, logic [257:0] d, logic ordy, logic fl);
    in_valid2 = v; in_ctrl2 = c; in_data2 = d; out_ready2 = ordy; flush2 = fl;
  endtask

  task automatic randomize_inputs();
    drive1(($urandom_range(3) != 0), 24'($urandom), {$urandom, $urandom, $urandom, $urandom, 1'($urandom)},
           ($urandom_range(9) < 6), ($urandom_range(99) < 3));
    drive2(2'($urandom), {16'($urandom), $urandom},
           {2'($urandom), $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
           ($urandom_range(9) < 6), ($urandom_range(99) < 3));
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      mcnt[k] = 0; mready[k] = 1'b1; mhead[k] = '0;
    end

    // Reset with garbage on every input
    rst_n = 1'b0;
    drive1(1'b1, 24'hFFFFFF, '1, 1'b1, 1'b1);
    drive2(2'b11, '1, '1, 1'b1, 1'b0);
    cycle();
    cycle();
    chk("rst_out_valid", 300'(out_valid1), 300'(0));
    chk("rst_out_ctrl",  300'(out_ctrl1),  300'(0));
    chk("rst_occupancy", 300'(occ2),       300'(0));
    rst_n = 1'b1;
    drive1(1'b0, 24'h0, '0, 1'b0, 1'b0);
    drive2(2'b00, '0, '0, 1'b0, 1'b0);
    cycle();
    chk("rst_in_ready", 300'(in_ready1), 300'(1));

    // Single push with out_ready=1: one-cycle latency, then drains
    drive1(1'b1, 24'h00ABCD, 129'h100, 1'b1, 1'b0);
    cycle();
    chk("lat_out_ctrl", 300'(out_ctrl1), 300'(24'h00ABCD));
    chk("lat_out_data", 300'(out_data1), 300'(129'h100));
    chk("lat_occ",      300'(occ1),      300'(1));
    drive1(1'b0, 24'h0, '0, 1'b1, 1'b0);
    cycle();
    chk("lat_occ_drain", 300'(occ1), 300'(0));

    // Fill with A,B; C held off; then drain in order
    drive1(1'b1, 24'h00000A, 129'hA0, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 24'h00000B, 129'hB0, 1'b0, 1'b0);
    cycle();
    chk("full_occ",   300'(occ1),      300'(2));
    chk("full_ready", 300'(in_ready1), 300'(0));
    drive1(1'b1, 24'h00000C, 129'hC0, 1'b0, 1'b0);
    cycle();
    chk("full_hold_head", 300'(out_ctrl1), 300'(24'h00000A));
    drive1(1'b1, 24'h00000C, 129'hC0, 1'b1, 1'b0);
    cycle();
    chk("drain_b",       300'(out_ctrl1), 300'(24'h00000B));
    chk("drain_ready",   300'(in_ready1), 300'(1));
    cycle();
    chk("drain_c",       300'(out_ctrl1), 300'(24'h00000C));
    drive1(1'b0, 24'h0, '0, 1'b1, 1'b0);
    cycle();

    // Flush from FULL with a same-cycle offer
    drive1(1'b1, 24'h000011, 129'h1100, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 24'h000022, 129'h2200, 1'b0, 1'b0);
    cycle();
    drive1(1'b1, 24'h000033, 129'h3300, 1'b0, 1'b1);
    cycle();
    chk("flush_valid", 300'(out_valid1), 300'(0));
    chk("flush_ctrl",  300'(out_ctrl1),  300'(0));
    chk("flush_data",  300'(out_data1),  300'(129'h1100));
    chk("flush_occ",   300'(occ1),       300'(0));
    chk("flush_ready", 300'(in_ready1),  300'(1));
    drive1(1'b0, 24'h0, '0, 1'b1, 1'b0);
    cycle();
    chk("flush_no_leak", 300'(out_valid1), 300'(0));

    // Streaming: push&pop every cycle keeps occupancy at 1, in order
    drive1(1'b1, 24'd0, 129'd0, 1'b1, 1'b0);
    cycle();
    for (int i = 1; i <= 16; i++) begin
      drive1(1'b1, 24'(i), 129'(i * 16), 1'b1, 1'b0);
      cycle();
      chk("stream_occ",  300'(occ1),      300'(1));
      chk("stream_ctrl", 300'(out_ctrl1), 300'(i));
    end
    drive1(1'b0, 24'h0, '0, 1'b1, 1'b0);
    cycle();

    // Two lanes, only lane 0 valid: lane 1 ctrl captured as zero
    drive2(2'b01, {24'hFFFFFF, 24'h123456}, 258'h5, 1'b0, 1'b0);
    cycle();
    chk("lane_valid",  300'(out_valid2),       300'(2'b01));
    chk("lane1_ctrl",  300'(out_ctrl2[47:24]), 300'(0));
    chk("lane0_ctrl",  300'(out_ctrl2[23:0]),  300'(24'h123456));
    drive2(2'b00, '0, '0, 1'b1, 1'b0);
    cycle();

    // Mid-operation reset discards held groups
    drive1(1'b1, 24'h000077, 129'h77, 1'b0, 1'b0);
    drive2(2'b11, 48'h1, 258'h1, 1'b0, 1'b0);
    cycle();
    cycle();
    rst_n = 1'b0;
    drive1(1'b1, 24'hFFFFFF, '1, 1'b1, 1'b0);
    cycle();
    chk("midrst_occ", 300'(occ1), 300'(0));
    rst_n = 1'b1;

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      rst_n = ($urandom_range(499) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
